// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid/ready handshake, a two-entry skid buffer
// and a synchronous flush. CTRL is forced to zero on bubbles.

module pipe_stage_reg #(
  parameter int unsigned CTRL_W     = 10,
  parameter int unsigned DATA_W     = 287,
  parameter bit          CLEAR_DATA = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              accept;
  logic              emit;

  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid & in_ready_q;
  assign emit      = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      // Anything accepted this cycle is dropped along with the held entries.
      state_d     = StEmpty;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (CLEAR_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d     = StOne;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        StOne: begin
          if (accept && emit) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (accept) begin
            state_d     = StFull;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (emit) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          // in_ready is low here, so only the drain path exists.
          if (emit) begin
            state_d     = StOne;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
          end
        end
        default: state_d = StEmpty;
      endcase
    end

    in_ready_d = (state_d != StFull);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  // DATA only carries a reset when it is meant to be cleared; otherwise plain flops.
  if (CLEAR_DATA) begin : g_data_rst
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        main_data_q <= '0;
        skid_data_q <= '0;
      end else begin
        main_data_q <= main_data_d;
        skid_data_q <= skid_data_d;
      end
    end
  end else begin : g_data_norst
    always_ff @(posedge clk) begin
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign occupancy = state_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign out_data  = (CLEAR_DATA && !out_valid) ? '0 : main_data_q;

  // Outputs must not move while the downstream stage is stalling.
  a_stall_stable: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_ctrl) && $stable(out_data)));

  a_ready_tracks_full: assert property (@(posedge clk) disable iff (reset)
    in_ready == (state_q != StFull));

  a_bubble_ctrl_zero: assert property (@(posedge clk) disable iff (reset)
    !out_valid |-> (out_ctrl == '0));

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed-vector and scoreboard bench for pipe_stage_reg; two instances cover both CLEAR_DATA
// settings under identical stimulus.

module tb_pipe_stage_reg;

  localparam int CW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          n_in_ready, c_in_ready;
  logic          n_out_valid, c_out_valid;
  logic [CW-1:0] n_out_ctrl, c_out_ctrl;
  logic [DW-1:0] n_out_data, c_out_data;
  logic [1:0]    n_occ, c_occ;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b0)) u_keep (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (n_in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (n_out_valid),
    .out_ready (out_ready),
    .out_ctrl  (n_out_ctrl),
    .out_data  (n_out_data),
    .occupancy (n_occ)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA(1'b1)) u_clear (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (c_in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (c_out_valid),
    .out_ready (out_ready),
    .out_ctrl  (c_out_ctrl),
    .out_data  (c_out_data),
    .occupancy (c_occ)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input logic v, input logic [CW-1:0] c,
                             input logic [1:0] occ, input logic rdy);
    cmp({tag, " keep.valid"}, 32'(n_out_valid), 32'(v));
    cmp({tag, " keep.ctrl"},  32'(n_out_ctrl),  32'(c));
    cmp({tag, " keep.occ"},   32'(n_occ),       32'(occ));
    cmp({tag, " keep.ready"}, 32'(n_in_ready),  32'(rdy));
    cmp({tag, " clr.valid"},  32'(c_out_valid), 32'(v));
    cmp({tag, " clr.ctrl"},   32'(c_out_ctrl),  32'(c));
    cmp({tag, " clr.occ"},    32'(c_occ),       32'(occ));
    cmp({tag, " clr.ready"},  32'(c_in_ready),  32'(rdy));
  endtask

  task automatic drive(input logic iv, input logic orr, input logic fl,
                       input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid  = iv;
    out_ready = orr;
    flush     = fl;
    in_ctrl   = c;
    in_data   = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          iv;
    logic          orr;
    logic          fl;
    logic [CW-1:0] ctrl;
    logic          ev;
    logic [CW-1:0] ec;
    logic [1:0]    eocc;
    logic          erdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic iv, input logic orr, input logic fl, input logic [CW-1:0] c,
                     input logic ev, input logic [CW-1:0] ec, input logic [1:0] eocc,
                     input logic erdy);
    vec_t v;
    v.iv = iv; v.orr = orr; v.fl = fl; v.ctrl = c;
    v.ev = ev; v.ec = ec; v.eocc = eocc; v.erdy = erdy;
    vecs.push_back(v);
  endtask

  logic [CW+DW-1:0] model[$];

  initial begin
    // Back-to-back streaming with out_ready high: one-cycle latency, one per cycle.
    for (int i = 1; i <= 8; i++) add(1, 1, 0, 10'(i), 1, 10'(i), 2'd1, 1);
    add(0, 1, 0, 10'h000, 0, 10'h000, 2'd0, 1);
    // Stall: A, B fill both entries, C is held off until drain.
    add(1, 0, 0, 10'h011, 1, 10'h011, 2'd1, 1);
    add(1, 0, 0, 10'h022, 1, 10'h011, 2'd2, 0);
    add(1, 0, 0, 10'h033, 1, 10'h011, 2'd2, 0);
    add(1, 1, 0, 10'h033, 1, 10'h022, 2'd1, 1);
    add(1, 1, 0, 10'h033, 1, 10'h033, 2'd1, 1);
    add(0, 1, 0, 10'h000, 0, 10'h000, 2'd0, 1);
    // Flush at FULL with a simultaneous push.
    add(1, 0, 0, 10'h00A, 1, 10'h00A, 2'd1, 1);
    add(1, 0, 0, 10'h00B, 1, 10'h00A, 2'd2, 0);
    add(1, 0, 1, 10'h3FF, 0, 10'h000, 2'd0, 1);
    add(0, 1, 0, 10'h000, 0, 10'h000, 2'd0, 1);
    // Flush while empty and accepting: the accepted entry is discarded.
    add(1, 1, 1, 10'h3FF, 0, 10'h000, 2'd0, 1);
    add(0, 1, 0, 10'h000, 0, 10'h000, 2'd0, 1);

    drive(0, 0, 0, '0, '0);
    reset = 1'b1;
    #2;
    check_state("reset", 0, '0, 2'd0, 1);
    cmp("reset clr.data", 32'(c_out_data), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].orr, vecs[i].fl, vecs[i].ctrl, 16'hA000 ^ 16'(vecs[i].ctrl));
      step();
      check_state($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ec, vecs[i].eocc, vecs[i].erdy);
      if (vecs[i].ev) begin
        cmp($sformatf("vec%0d keep.data", i), 32'(n_out_data), 32'(16'hA000 ^ 16'(vecs[i].ec)));
        cmp($sformatf("vec%0d clr.data", i),  32'(c_out_data), 32'(16'hA000 ^ 16'(vecs[i].ec)));
      end
    end

    // Flush with a held entry: DATA cleared only when CLEAR_DATA is set.
    drive(1, 0, 0, 10'h005, 16'hDEAD);
    step();
    cmp("dead keep.data", 32'(n_out_data), 32'hDEAD);
    cmp("dead clr.data",  32'(c_out_data), 32'hDEAD);
    drive(0, 0, 1, '0, '0);
    step();
    check_state("deadflush", 0, '0, 2'd0, 1);
    cmp("deadflush keep.data", 32'(n_out_data), 32'hDEAD);
    cmp("deadflush clr.data",  32'(c_out_data), 32'h0);

    // Drain to empty without flush: CLEAR_DATA masks the bubble's data.
    drive(1, 1, 0, 10'h007, 16'h1234);
    step();
    drive(0, 1, 0, '0, '0);
    step();
    check_state("drain", 0, '0, 2'd0, 1);
    cmp("drain keep.data", 32'(n_out_data), 32'h1234);
    cmp("drain clr.data",  32'(c_out_data), 32'h0);

    // Asynchronous reset mid-cycle while FULL.
    drive(1, 0, 0, 10'h001, 16'h0001);
    step();
    drive(1, 0, 0, 10'h002, 16'h0002);
    step();
    check_state("prefull", 1, 10'h001, 2'd2, 0);
    #2;
    reset = 1'b1;
    #1;
    check_state("asyncrst", 0, '0, 2'd0, 1);
    cmp("asyncrst clr.data", 32'(c_out_data), 32'h0);
    drive(0, 0, 0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Random traffic against a FIFO scoreboard.
    for (int cyc = 0; cyc < 10000; cyc++) begin
      logic iv, orr, fl, acc, emt;
      logic [CW-1:0] c;
      logic [DW-1:0] d;
      iv  = 1'($urandom_range(0, 1));
      orr = 1'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 31) == 0);
      c   = CW'($urandom);
      d   = DW'($urandom);
      drive(iv, orr, fl, c, d);
      acc = iv && (model.size() < 2);
      emt = orr && (model.size() > 0);
      @(posedge clk);
      if (fl) begin
        model.delete();
      end else begin
        if (emt) void'(model.pop_front());
        if (acc) model.push_back({c, d});
      end
      #1;
      if (model.size() > 0) begin
        check_state("rand", 1, model[0][CW+DW-1:DW], 2'(model.size()), model.size() < 2);
        cmp("rand keep.data", 32'(n_out_data), 32'(model[0][DW-1:0]));
        cmp("rand clr.data",  32'(c_out_data), 32'(model[0][DW-1:0]));
      end else begin
        check_state("rand", 0, '0, 2'd0, 1);
        cmp("rand clr.data", 32'(c_out_data), 32'h0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
